// File: rtl/key_cmd_frontend_if.sv
// key_cmd_frontend_if: key/switch inputs, tree status and
// command outputs between the board front end and the tree store.
interface key_cmd_frontend_if #(
    parameter int DATA_W = 4
);
    logic [2:0]        k_raw;
    logic [DATA_W-1:0] sw;
    logic              buf_full;
    logic              buf_empty;
    logic              op_done;
    logic              cmd_find;
    logic              cmd_insert;
    logic              cmd_remove;
    logic [DATA_W-1:0] cmd_data;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;
    logic [7:0]        cmd_count;

    modport master (
        input  k_raw, sw, buf_full, buf_empty, op_done,
        output cmd_find, cmd_insert, cmd_remove, cmd_data,
        output busy, err, err_code, cmd_count
    );

    modport slave (
        output k_raw, sw, buf_full, buf_empty, op_done,
        input  cmd_find, cmd_insert, cmd_remove, cmd_data,
        input  busy, err, err_code, cmd_count
    );
endinterface

// File: rtl/key_cmd_frontend.sv
// key_cmd_frontend: debounces push buttons into single-cycle
// tree commands, one outstanding, with error and op counting.
module key_cmd_frontend #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DATA_W          = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic               clk,
    input  logic               rst,
    key_cmd_frontend_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]        r_sync1, r_sync2, r_deb, r_deb_d, r_press;
    logic [7:0]        r_db_cnt [3];
    state_t            r_state, w_state_nxt;
    logic [2:0]        r_op, w_op_nxt, w_sel;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_err, w_err_nxt;
    logic [1:0]        r_code, w_code_nxt;
    logic [7:0]        r_count, w_count_nxt;
    logic [15:0]       r_to, w_to_nxt;

    // Sync, debounce and rising-edge detect, bitwise per key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            r_press <= '0;
            for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= bus.k_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_code  <= '0;
            r_count <= '0;
            r_to    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
            r_code  <= w_code_nxt;
            r_count <= w_count_nxt;
            r_to    <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
        w_code_nxt  = r_code;
        w_count_nxt = r_count;
        w_to_nxt    = r_to;
        // one-hot {remove, insert, find}; insert > remove > find
        if (r_press[1])      w_sel = 3'b010;
        else if (r_press[2]) w_sel = 3'b100;
        else if (r_press[0]) w_sel = 3'b001;
        else                 w_sel = 3'b000;
        unique case (r_state)
            S_IDLE: begin
                if (w_sel != 3'b000) begin
                    if (w_sel[1] && bus.buf_full) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = 2'd1;
                    end else if (!w_sel[1] && bus.buf_empty) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = 2'd2;
                    end else begin
                        w_op_nxt    = w_sel;
                        w_data_nxt  = bus.sw;
                        w_err_nxt   = 1'b0;
                        w_code_nxt  = 2'd0;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_to_nxt    = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.op_done) begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = r_count + 8'd1;
                end else if (r_to == TO_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                    w_code_nxt  = 2'd3;
                end else begin
                    w_to_nxt = r_to + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.cmd_find   = (r_state == S_ISSUE) & r_op[0];
    assign bus.cmd_insert = (r_state == S_ISSUE) & r_op[1];
    assign bus.cmd_remove = (r_state == S_ISSUE) & r_op[2];
    assign bus.cmd_data   = r_data;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.err        = r_err;
    assign bus.err_code   = r_code;
    assign bus.cmd_count  = r_count;
endmodule

// File: tb/tb_key_cmd_frontend.sv
// tb_key_cmd_frontend: directed checks of debounce latency,
// reject paths, timeout, priority and async reset.
module tb_key_cmd_frontend;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ins = 0;
  int   n_rem = 0;
  int   n_fnd = 0;
  int   n_busy = 0;
  int   snap;

  key_cmd_frontend_if #(.DATA_W(4)) bus ();

  key_cmd_frontend #(
    .DEBOUNCE_CYCLES(4),
    .DATA_W(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cmd_insert) n_ins++;
    if (bus.cmd_remove) n_rem++;
    if (bus.cmd_find)   n_fnd++;
    if (bus.busy)       n_busy++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int key, input int hold);
    bus.k_raw[key] = 1'b1;
    wait_n(hold);
    bus.k_raw[key] = 1'b0;
    wait_n(8);
  endtask

  task automatic serve();
    bus.op_done = 1'b1;
    wait_n(1);
    bus.op_done = 1'b0;
  endtask

  initial begin
    bus.k_raw     = 3'b000;
    bus.sw        = 4'd0;
    bus.buf_full  = 1'b0;
    bus.buf_empty = 1'b0;
    bus.op_done   = 1'b0;
    wait_n(3);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_code", bus.err_code, 2'd0);
    chk("rst_count", bus.cmd_count, 8'd0);
    chk("rst_cmd", {bus.cmd_find, bus.cmd_insert,
                    bus.cmd_remove}, 3'b000);
    rst = 1'b0;
    wait_n(2);

    bus.sw = 4'd10;
    bus.k_raw[1] = 1'b1;
    wait_n(7);
    chk("t1_ins_t6", bus.cmd_insert, 1'b0);
    chk("t1_busy_t6", bus.busy, 1'b0);
    wait_n(1);
    chk("t1_ins_t7", bus.cmd_insert, 1'b1);
    chk("t1_data", bus.cmd_data, 4'd10);
    chk("t1_busy_t7", bus.busy, 1'b1);
    wait_n(1);
    chk("t1_ins_t8", bus.cmd_insert, 1'b0);
    chk("t1_busy_t8", bus.busy, 1'b1);
    serve();
    chk("t1_busy_done", bus.busy, 1'b0);
    chk("t1_count", bus.cmd_count, 8'd1);
    chk("t1_err", bus.err, 1'b0);
    wait_n(2);
    bus.k_raw[1] = 1'b0;
    wait_n(10);
    chk("t1_one_pulse", n_ins, 1);

    snap = n_busy;
    for (int i = 0; i < 8; i++) begin
      bus.k_raw[0] = ~bus.k_raw[0];
      wait_n(2);
    end
    bus.k_raw[0] = 1'b0;
    wait_n(10);
    chk("t2_no_find", n_fnd, 0);
    chk("t2_no_busy", n_busy, snap);
    chk("t2_count", bus.cmd_count, 8'd1);

    bus.buf_empty = 1'b1;
    press(0, 10);
    chk("t3_no_find", n_fnd, 0);
    chk("t3_err", bus.err, 1'b1);
    chk("t3_code", bus.err_code, 2'd2);
    bus.buf_empty = 1'b0;
    bus.sw = 4'd3;
    bus.k_raw[0] = 1'b1;
    wait_n(8);
    chk("t3_find", bus.cmd_find, 1'b1);
    chk("t3_data", bus.cmd_data, 4'd3);
    chk("t3_err_clr", bus.err, 1'b0);
    chk("t3_code_clr", bus.err_code, 2'd0);
    wait_n(1);
    serve();
    chk("t3_count", bus.cmd_count, 8'd2);
    bus.k_raw[0] = 1'b0;
    wait_n(8);

    bus.buf_full = 1'b1;
    press(1, 10);
    chk("t4_no_ins", n_ins, 1);
    chk("t4_err", bus.err, 1'b1);
    chk("t4_code", bus.err_code, 2'd1);
    bus.sw = 4'd6;
    bus.k_raw[2] = 1'b1;
    wait_n(8);
    chk("t4_remove", bus.cmd_remove, 1'b1);
    chk("t4_data", bus.cmd_data, 4'd6);
    chk("t4_err_clr", bus.err, 1'b0);
    wait_n(1);
    serve();
    chk("t4_count", bus.cmd_count, 8'd3);
    bus.k_raw[2] = 1'b0;
    bus.buf_full = 1'b0;
    wait_n(8);

    bus.sw = 4'd5;
    bus.k_raw[1] = 1'b1;
    wait_n(8);
    chk("t5_ins", bus.cmd_insert, 1'b1);
    bus.k_raw[2] = 1'b1;
    wait_n(8);
    chk("t5_busy_last", bus.busy, 1'b1);
    wait_n(1);
    chk("t5_busy_fall", bus.busy, 1'b0);
    chk("t5_err", bus.err, 1'b1);
    chk("t5_code", bus.err_code, 2'd3);
    chk("t5_count", bus.cmd_count, 8'd3);
    wait_n(6);
    bus.k_raw = 3'b000;
    wait_n(10);
    chk("t5_no_remove", n_rem, 1);
    chk("t5_one_ins", n_ins, 2);

    bus.sw = 4'd9;
    bus.k_raw = 3'b011;
    wait_n(8);
    chk("t6_ins", bus.cmd_insert, 1'b1);
    chk("t6_find", bus.cmd_find, 1'b0);
    wait_n(2);
    chk("t6_busy_wait", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_err", bus.err, 1'b0);
    chk("t6_rst_count", bus.cmd_count, 8'd0);
    chk("t6_rst_cmd", {bus.cmd_find, bus.cmd_insert,
                       bus.cmd_remove}, 3'b000);
    bus.k_raw = 3'b000;
    wait_n(3);
    rst = 1'b0;
    wait_n(2);
    chk("t6_no_find", n_fnd, 1);
    bus.sw = 4'd7;
    bus.k_raw[2] = 1'b1;
    wait_n(8);
    chk("t6_remove", bus.cmd_remove, 1'b1);
    chk("t6_data", bus.cmd_data, 4'd7);
    wait_n(1);
    serve();
    chk("t6_count", bus.cmd_count, 8'd1);
    bus.k_raw[2] = 1'b0;
    wait_n(8);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/key_cmd_frontend.md
Name: key_cmd_frontend

Overview:
- Upstream stage of the tree store on the FPGA board.
- Turns raw push-button and switch inputs into clean, single-cycle find/insert/remove commands with latched data.
- Runs a one-outstanding-command handshake with the tree: waits for its done pulse, and refuses commands the tree cannot accept (full/empty).
- Reports errors and counts completed operations for board display.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles (after sync) needed to accept a key level change; legal range 1..255
DATA_W, 4, width of switch data and command data
TIMEOUT_CYCLES, 255, max cycles to wait for op_done before aborting; legal range 1..65535

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
k_raw  in  3  raw keys, active-high: [0]=find, [1]=insert, [2]=remove
sw  in  DATA_W  switch data operand
buf_full  in  1  tree full status
buf_empty  in  1  tree empty status
op_done  in  1  one-cycle completion pulse from tree
cmd_find  out  1  one-cycle find command
cmd_insert  out  1  one-cycle insert command
cmd_remove  out  1  one-cycle remove command
cmd_data  out  DATA_W  operand, valid from cmd pulse until next command
busy  out  1  command outstanding
err  out  1  sticky error flag
err_code  out  2  0=none, 1=insert while full, 2=find/remove while empty, 3=timeout
cmd_count  out  8  completed operations, wraps 255->0

Behaviour:
- Reset (async, immediate):
  - All outputs 0.
  - FSM to IDLE.
  - Synchronizers, debounced levels, debounce counters and timeout counter cleared.
  - Reset mid-WAIT aborts the operation with no pulse and no count.
- Synchronizer: 2 flops per key.
- Debounce (per key):
  - Counter increments each cycle the synchronized level differs from the debounced level.
  - Counter clears on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press event: registered rising edge of a debounced level; one cycle wide. Releases generate nothing.
- Latency: raw key first sampled high at edge t and held ->
  - debounced level rises at edge t+D+1;
  - press event is seen by the FSM at edge t+D+2;
  - cmd_* rises at edge t+D+3 and falls at edge t+D+4.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, on a press event:
  - Simultaneous presses are resolved by priority insert > remove > find; losers are dropped silently.
  - Insert with buf_full=1: no command, err=1, err_code=1, stay IDLE.
  - Find or remove with buf_empty=1: no command, err=1, err_code=2, stay IDLE.
  - Otherwise: latch sw into cmd_data, clear err and err_code, go to ISSUE.
  - buf_full and buf_empty are sampled on the same edge as the press event.
- ISSUE:
  - Exactly one cmd_* is high for this single cycle; busy=1.
  - Timeout counter is cleared.
  - Next state WAIT.
- WAIT:
  - busy=1; timeout counter increments each cycle.
  - op_done=1: go to IDLE, cmd_count+1, busy drops on that edge.
  - Counter reaches TIMEOUT_CYCLES without op_done: go to IDLE, err=1, err_code=3, cmd_count unchanged.
  - op_done on the same cycle as timeout expiry: done wins, no error.
- Press events in ISSUE/WAIT are discarded, not queued. Keys must be released and re-pressed.
- op_done in IDLE or ISSUE is ignored.
- cmd_find, cmd_insert and cmd_remove are mutually exclusive and never high outside ISSUE.
- Key held down produces exactly one command.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8):
1. Insert path: after reset, sw=10, k_raw[1] high at edge t held 12 cycles; op_done pulse 2 cycles after the cmd pulse -> cmd_insert high for exactly one cycle starting edge t+7, cmd_data=10, busy high from t+7 until the op_done edge, cmd_count=1, err=0.
2. Bounce rejection: k_raw[0] toggled every 2 cycles for 16 cycles, then low -> no cmd pulse, busy stays 0, cmd_count unchanged.
3. Empty rejection:
   - buf_empty=1, press find -> no pulse, err=1, err_code=2.
   - Then buf_empty=0, press find with sw=3 -> cmd_find pulse, cmd_data=3, err=0, err_code=0.
4. Full rejection: buf_full=1, press insert -> no pulse, err_code=1. A remove pressed while buf_full=1 and buf_empty=0 is still issued.
5. Timeout and busy discard:
   - Press insert, never assert op_done; press remove during WAIT.
   - Required: busy falls 8 cycles after entering WAIT, err_code=3, no cmd_remove ever issued, cmd_count unchanged.
6. Priority and reset:
   - k_raw[0] and k_raw[1] rise on the same edge -> only cmd_insert.
   - rst asserted mid-WAIT -> busy, err and cmd_* go to 0 immediately without waiting for a clock edge; after release, a new press works normally.
